// File: rtl/alu_math_px_pkg.sv
// Shared opcode/state types and opcode legality check for the byte-serial ALU.
package alu_math_px_pkg;

   typedef enum logic [3:0] {
      OP_ADD    = 4'd0,
      OP_SUB_AB = 4'd1,
      OP_SUB_BA = 4'd2,
      OP_MUL    = 4'd3,
      OP_DIV_AB = 4'd4,
      OP_DIV_BA = 4'd5,
      OP_INC_A  = 4'd6,
      OP_INC_B  = 4'd7,
      OP_CLR    = 4'd8,
      OP_ACCUM  = 4'd9
   } op_t;

   typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, EXEC, RESULT} state_t;

   localparam int NUM_OPS = 10;

   function automatic logic is_legal_op(input logic [3:0] code);
      return int'(code) < NUM_OPS;
   endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative MSB-first shift/add multiplier and restoring divider, one bit per cycle.
// The start cycle performs the first step; done flags the OPW-th step with product/quotient valid.
module alu_iter_muldiv #(
   parameter int OPW = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             mode,
   input  logic [OPW-1:0]   a,
   input  logic [OPW-1:0]   b,
   output logic             done,
   output logic [2*OPW-1:0] product,
   output logic [OPW-1:0]   quotient,
   output logic             div_by_zero
);
   localparam int CW = $clog2(OPW + 1);

   logic [2*OPW-1:0] acc, c_acc, n_acc;
   logic [OPW-1:0]   sh, c_sh, n_sh;
   logic [OPW-1:0]   opnd, c_op;
   logic [CW-1:0]    cnt, c_cnt;
   logic [OPW:0]     trial, rem;
   logic             run, active, qbit;

   // sh carries the multiplier (mul) or the dividend turning into the quotient (div)
   always_comb begin
      active = start || run;
      c_acc  = start ? '0 : acc;
      c_sh   = start ? a  : sh;
      c_op   = start ? b  : opnd;
      c_cnt  = start ? '0 : cnt;
      trial  = {c_acc[OPW-1:0], c_sh[OPW-1]};
      rem    = trial;
      qbit   = 1'b0;
      if (mode) begin
         if (trial >= {1'b0, c_op}) begin
            rem  = trial - {1'b0, c_op};
            qbit = 1'b1;
         end
         n_acc = {{OPW{1'b0}}, rem[OPW-1:0]};
         n_sh  = (c_sh << 1) | OPW'(qbit);
      end else begin
         n_acc = (c_acc << 1) + (c_sh[OPW-1] ? {{OPW{1'b0}}, c_op} : '0);
         n_sh  = c_sh << 1;
      end
      done = active && (c_cnt == CW'(OPW - 1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc  <= '0;
         sh   <= '0;
         opnd <= '0;
         cnt  <= '0;
         run  <= 1'b0;
      end else if (active) begin
         acc  <= n_acc;
         sh   <= n_sh;
         opnd <= c_op;
         cnt  <= c_cnt + CW'(1);
         run  <= !done;
      end
   end

   assign product     = n_acc;
   assign quotient    = n_sh;
   assign div_by_zero = mode && (b == '0);

endmodule

// File: rtl/alu_math_px.sv
// Byte-serial command ALU: opcode byte, then MSB-first operands; result = k*f(A,B)+c mod 2^RW.
// ADD ready 6 cycles after the command, MUL/DIV 5+OPW; busy stays high until the ready cycle ends.
module alu_math_px
   import alu_math_px_pkg::*;
#(
   parameter int DW  = 8,
   parameter int OPW = 16,
   parameter int RW  = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          ctl,
   input  logic [DW-1:0] dat,
   input  logic [DW-1:0] k_val,
   input  logic [DW-1:0] c_val,
   output logic [RW-1:0] result,
   output logic          ready,
   output logic          err,
   output logic          busy
);
   localparam int NB = OPW / DW;
   localparam int CW = $clog2(NB + 1);

   state_t           state;
   op_t              op;
   logic [OPW-1:0]   a_r, b_r;
   logic [DW-1:0]    k_r, c_r;
   logic [CW-1:0]    cnt;
   logic             eng_run;

   logic             is_md, eng_mode, eng_start, eng_done, eng_dbz;
   logic [OPW-1:0]   eng_a, eng_b, eng_quot;
   logic [2*OPW-1:0] eng_prod;
   logic [RW-1:0]    a_x, b_x, f_val, val;
   logic             legal;

   assign legal     = ((dat >> 4) == '0) && is_legal_op(dat[3:0]);
   assign is_md     = op inside {OP_MUL, OP_DIV_AB, OP_DIV_BA};
   assign eng_mode  = (op == OP_DIV_AB) || (op == OP_DIV_BA);
   assign eng_a     = (op == OP_DIV_BA) ? b_r : a_r;
   assign eng_b     = (op == OP_DIV_BA) ? a_r : b_r;
   assign eng_start = (state == EXEC) && is_md && !eng_dbz && !eng_run;

   alu_iter_muldiv #(.OPW(OPW)) u_muldiv (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (eng_start),
      .mode        (eng_mode),
      .a           (eng_a),
      .b           (eng_b),
      .done        (eng_done),
      .product     (eng_prod),
      .quotient    (eng_quot),
      .div_by_zero (eng_dbz)
   );

   always_comb begin
      a_x = RW'(a_r);
      b_x = RW'(b_r);
      case (op)
         OP_ADD:    f_val = a_x + b_x;
         OP_SUB_AB: f_val = a_x - b_x;
         OP_SUB_BA: f_val = b_x - a_x;
         OP_MUL:    f_val = RW'(eng_prod);
         OP_DIV_AB,
         OP_DIV_BA: f_val = RW'(eng_quot);
         OP_INC_A:  f_val = a_x + RW'(1);
         OP_INC_B:  f_val = b_x + RW'(1);
         default:   f_val = '0;
      endcase
      if (op == OP_CLR)        val = '0;
      else if (op == OP_ACCUM) val = result + a_x;
      else if (eng_dbz)        val = '1;
      else                     val = RW'(k_r) * f_val + RW'(c_r);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         op      <= OP_ADD;
         a_r     <= '0;
         b_r     <= '0;
         k_r     <= '0;
         c_r     <= '0;
         cnt     <= '0;
         eng_run <= 1'b0;
         result  <= '0;
         ready   <= 1'b0;
         err     <= 1'b0;
         busy    <= 1'b0;
      end else begin
         ready <= 1'b0;
         err   <= (state != IDLE) && ctl;
         case (state)
            IDLE: if (ctl) begin
               if (legal) begin
                  op   <= op_t'(dat[3:0]);
                  k_r  <= k_val;
                  c_r  <= c_val;
                  cnt  <= '0;
                  busy <= 1'b1;
                  case (op_t'(dat[3:0]))
                     OP_INC_B: state <= LOAD_B;
                     OP_CLR:   state <= EXEC;
                     default:  state <= LOAD_A;
                  endcase
               end else begin
                  err <= 1'b1;
               end
            end
            LOAD_A: begin
               a_r <= (a_r << DW) | OPW'(dat);
               if (cnt == CW'(NB - 1)) begin
                  cnt   <= '0;
                  state <= (op == OP_INC_A || op == OP_ACCUM) ? EXEC : LOAD_B;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            LOAD_B: begin
               b_r <= (b_r << DW) | OPW'(dat);
               if (cnt == CW'(NB - 1)) begin
                  cnt   <= '0;
                  state <= EXEC;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            EXEC: begin
               if (eng_start) eng_run <= 1'b1;
               // divide-by-zero and single-cycle ops finish here; engine ops wait for done
               if (!is_md || eng_dbz || eng_done) begin
                  eng_run <= 1'b0;
                  result  <= val;
                  ready   <= 1'b1;
                  state   <= RESULT;
                  if (eng_dbz) err <= 1'b1;
               end
            end
            RESULT: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
